// File: rtl/sb_rx_if.sv
// sb_rx_if: sideband line inputs and decoded byte/transaction outputs of the receive controller.
interface sb_rx_if #(parameter int MAX_LEN = 16);
    localparam int LW = $clog2(MAX_LEN + 1);
    logic          enable;
    logic          sb_in;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_err;
    logic          txn_start;
    logic          txn_type;
    logic          payload_valid;
    logic [7:0]    payload_data;
    logic          txn_end;
    logic [LW-1:0] txn_len;
    logic          txn_err;
    logic          txn_active;
    modport master(output enable, sb_in,
                   input byte_valid, byte_data, frame_err, txn_start, txn_type, payload_valid,
                   payload_data, txn_end, txn_len, txn_err, txn_active);
    modport slave(input enable, sb_in,
                  output byte_valid, byte_data, frame_err, txn_start, txn_type, payload_valid,
                  payload_data, txn_end, txn_len, txn_err, txn_active);
endinterface

// File: rtl/sb_rx_controller.sv
// sb_rx_controller: serial sideband byte receiver with DLE-framed transaction parser.
module sb_rx_controller #(
    parameter logic [7:0] DLE     = 8'hFE,
    parameter logic [7:0] STX_CMD = 8'h05,
    parameter logic [7:0] STX_RSP = 8'h04,
    parameter logic [7:0] ETX     = 8'h40,
    parameter int         MAX_LEN = 16
) (
    input logic  clk,
    input logic  rst,
    sb_rx_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    typedef enum logic [1:0] {B_IDLE, B_DATA, B_STOP} b_t;
    typedef enum logic [1:0] {P_IDLE, P_SOF, P_BODY, P_ESC} p_t;
    b_t            b_st, b_nxt;
    p_t            p_st, p_nxt;
    logic [2:0]    bcnt;
    logic [7:0]    sh, b, pd_n;
    logic [LW-1:0] cnt, cnt_n, len_n;
    logic          stop_now, fe_now, in_txn, full;
    logic          start_n, pv_n, end_n, err_n, type_n;
    assign stop_now = b_st == B_STOP;
    assign fe_now   = stop_now && !bus.sb_in;
    assign in_txn   = p_st == P_BODY || p_st == P_ESC;
    assign full     = cnt == LW'(MAX_LEN);
    assign b        = bus.byte_data;
    assign bus.txn_active = in_txn;
    always_comb begin
        b_nxt = (b_st == B_IDLE) ? ((bus.enable && !bus.sb_in) ? B_DATA : B_IDLE) :
                (b_st == B_DATA) ? ((bcnt == 3'd7) ? B_STOP : B_DATA) : B_IDLE;
    end
    // A framing error inside a transaction aborts it in the same cycle the error is reported.
    always_comb begin
        p_nxt   = p_st;
        cnt_n   = cnt;
        len_n   = bus.txn_len;
        type_n  = bus.txn_type;
        pd_n    = bus.payload_data;
        start_n = 1'b0;
        pv_n    = 1'b0;
        end_n   = 1'b0;
        err_n   = 1'b0;
        if (fe_now) begin
            p_nxt = P_IDLE;
            err_n = in_txn;
        end else if (bus.byte_valid) begin
            case (p_st)
                P_IDLE: p_nxt = (b == DLE) ? P_SOF : P_IDLE;
                P_SOF: begin
                    start_n = b == STX_CMD || b == STX_RSP;
                    p_nxt   = start_n ? P_BODY : (b == DLE) ? P_SOF : P_IDLE;
                    type_n  = start_n ? (b == STX_RSP) : bus.txn_type;
                    cnt_n   = start_n ? '0 : cnt;
                end
                default: begin
                    if (p_st == P_BODY && b == DLE) begin
                        p_nxt = P_ESC;
                    end else if (p_st == P_ESC && b == ETX) begin
                        p_nxt = P_IDLE;
                        end_n = 1'b1;
                        len_n = cnt;
                    end else if ((p_st == P_ESC && b != DLE) || full) begin
                        p_nxt = P_IDLE;
                        err_n = 1'b1;
                    end else begin
                        p_nxt = P_BODY;
                        pv_n  = 1'b1;
                        pd_n  = b;
                        cnt_n = cnt + 1'b1;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            b_st              <= B_IDLE;
            p_st              <= P_IDLE;
            bcnt              <= '0;
            sh                <= '0;
            cnt               <= '0;
            bus.byte_valid    <= 1'b0;
            bus.byte_data     <= '0;
            bus.frame_err     <= 1'b0;
            bus.txn_start     <= 1'b0;
            bus.txn_type      <= 1'b0;
            bus.payload_valid <= 1'b0;
            bus.payload_data  <= '0;
            bus.txn_end       <= 1'b0;
            bus.txn_len       <= '0;
            bus.txn_err       <= 1'b0;
        end else begin
            b_st              <= b_nxt;
            p_st              <= p_nxt;
            bcnt              <= (b_st == B_DATA) ? bcnt + 3'd1 : 3'd0;
            sh                <= (b_st == B_DATA) ? {bus.sb_in, sh[7:1]} : sh;
            cnt               <= cnt_n;
            bus.byte_valid    <= stop_now && bus.sb_in;
            bus.byte_data     <= (stop_now && bus.sb_in) ? sh : bus.byte_data;
            bus.frame_err     <= fe_now;
            bus.txn_start     <= start_n;
            bus.txn_type      <= type_n;
            bus.payload_valid <= pv_n;
            bus.payload_data  <= pd_n;
            bus.txn_end       <= end_n;
            bus.txn_len       <= len_n;
            bus.txn_err       <= err_n;
        end
    end
endmodule
